// File: rtl/hls_run_ctrl_pkg.sv
// Shared types and constants for the HLS run sequencer.
package hls_run_ctrl_pkg;

    localparam int unsigned DEF_RUNS_W  = 16;
    localparam int unsigned DEF_WORDS_W = 32;
    localparam int unsigned DEF_TMO_W   = 24;
    localparam int unsigned ERR_CODE_W  = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_FINISH,
        S_ERR
    } state_t;

    localparam logic [ERR_CODE_W-1:0] ERR_NONE     = 2'd0;
    localparam logic [ERR_CODE_W-1:0] ERR_TIMEOUT  = 2'd1;
    localparam logic [ERR_CODE_W-1:0] ERR_OVERRUN  = 2'd2;
    localparam logic [ERR_CODE_W-1:0] ERR_UNDERRUN = 2'd3;

endpackage

// File: rtl/hls_run_ctrl_if.sv
// Kernel ap_ctrl_hs handshake plus the monitored vld/ack stream.
interface hls_run_ctrl_if;

    logic k_ap_start;
    logic k_ap_ready;
    logic k_ap_done;
    logic k_ap_idle;
    logic mon_vld;
    logic mon_ack;

    modport master (
        output k_ap_start,
        input  k_ap_ready,
        input  k_ap_done,
        input  k_ap_idle,
        input  mon_vld,
        input  mon_ack
    );

    modport slave (
        input  k_ap_start,
        output k_ap_ready,
        output k_ap_done,
        output k_ap_idle,
        output mon_vld,
        output mon_ack
    );

endinterface

// File: rtl/hls_run_ctrl_watchdog.sv
// Idle-cycle watchdog: counts enabled cycles without activity; limit 0 disables it.
module hls_run_ctrl_watchdog #(
    parameter int unsigned TMO_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic             enable,
    input  logic [TMO_W-1:0] limit,
    output logic             expired
);

    logic [TMO_W-1:0] limit_q;
    logic [TMO_W-1:0] count;

    // Expire is registered and holds until the owner clears, disables or reloads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            limit_q <= '0;
            count   <= '0;
            expired <= 1'b0;
        end else if (load) begin
            limit_q <= limit;
            count   <= '0;
            expired <= 1'b0;
        end else if (clear || !enable) begin
            count   <= '0;
            expired <= 1'b0;
        end else if ((limit_q != '0) && !expired) begin
            count   <= count + TMO_W'(1);
            expired <= ((count + TMO_W'(1)) == limit_q);
        end
    end

endmodule

// File: rtl/hls_run_ctrl.sv
// Sequences cfg_num_runs ap_ctrl_hs start handshakes and checks each run's word count.
module hls_run_ctrl
    import hls_run_ctrl_pkg::*;
#(
    parameter int unsigned RUNS_W  = DEF_RUNS_W,
    parameter int unsigned WORDS_W = DEF_WORDS_W,
    parameter int unsigned TMO_W   = DEF_TMO_W
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  cfg_start,
    input  logic [RUNS_W-1:0]     cfg_num_runs,
    input  logic [WORDS_W-1:0]    cfg_words_per_run,
    input  logic [TMO_W-1:0]      cfg_timeout,
    hls_run_ctrl_if.master        kif,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ERR_CODE_W-1:0] err_code,
    output logic [RUNS_W-1:0]     runs_done,
    output logic [WORDS_W-1:0]    words_seen
);

    state_t              state;
    logic                start_q;
    logic                done_lat;
    logic                expired;
    logic [RUNS_W-1:0]   num_runs_q;
    logic [WORDS_W-1:0]  words_q;

    logic                accept_c;
    logic                run_active_c;
    logic                xfer_c;
    logic                activity_c;
    logic                check_on_c;
    logic                at_target_c;
    logic                overrun_c;
    logic                done_any_c;
    logic                complete_c;
    logic                fault_c;
    logic [ERR_CODE_W-1:0] fault_code_c;

    // ap_idle is reported by the kernel but plays no part in sequencing.
    logic unused_idle;
    assign unused_idle = kif.k_ap_idle;

    assign kif.k_ap_start = start_q;

    assign accept_c     = (state == S_IDLE) && cfg_start;
    assign run_active_c = (state == S_START) || (state == S_WAIT);
    assign xfer_c       = kif.mon_vld && kif.mon_ack;
    assign activity_c   = kif.k_ap_ready || kif.k_ap_done || xfer_c;
    assign check_on_c   = (words_q != '0);
    assign at_target_c  = (words_seen == words_q);
    assign overrun_c    = xfer_c && check_on_c && at_target_c;
    assign done_any_c   = done_lat || kif.k_ap_done;
    assign complete_c   = (state == S_WAIT) && done_any_c && (!check_on_c || at_target_c);

    // A finished run beats a watchdog expiring on the same edge; an overrun beats both.
    assign fault_c      = run_active_c && (overrun_c || (expired && !complete_c));
    assign fault_code_c = overrun_c ? ERR_OVERRUN
                        : (done_any_c && check_on_c && !at_target_c) ? ERR_UNDERRUN
                        : ERR_TIMEOUT;

    hls_run_ctrl_watchdog #(
        .TMO_W (TMO_W)
    ) u_watchdog (
        .clk     (ap_clk),
        .rst     (ap_rst),
        .load    (accept_c),
        .clear   (activity_c),
        .enable  (run_active_c),
        .limit   (cfg_timeout),
        .expired (expired)
    );

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state      <= S_IDLE;
            start_q    <= 1'b0;
            done_lat   <= 1'b0;
            num_runs_q <= '0;
            words_q    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            err_code   <= ERR_NONE;
            runs_done  <= '0;
            words_seen <= '0;
        end else begin
            done <= 1'b0;
            if (fault_c) begin
                state    <= S_ERR;
                start_q  <= 1'b0;
                busy     <= 1'b0;
                error    <= 1'b1;
                err_code <= fault_code_c;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (cfg_start) begin
                            num_runs_q <= cfg_num_runs;
                            words_q    <= cfg_words_per_run;
                            runs_done  <= '0;
                            words_seen <= '0;
                            done_lat   <= 1'b0;
                            error      <= 1'b0;
                            err_code   <= ERR_NONE;
                            busy       <= 1'b1;
                            if (cfg_num_runs == '0) begin
                                state <= S_FINISH;
                            end else begin
                                state   <= S_START;
                                start_q <= 1'b1;
                            end
                        end
                    end
                    S_START: begin
                        if (xfer_c && (words_seen != '1)) begin
                            words_seen <= words_seen + WORDS_W'(1);
                        end
                        if (kif.k_ap_done) begin
                            done_lat <= 1'b1;
                        end
                        if (kif.k_ap_ready) begin
                            start_q <= 1'b0;
                            state   <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (complete_c) begin
                            runs_done  <= runs_done + RUNS_W'(1);
                            words_seen <= '0;
                            done_lat   <= 1'b0;
                            if ((runs_done + RUNS_W'(1)) < num_runs_q) begin
                                state   <= S_START;
                                start_q <= 1'b1;
                            end else begin
                                state <= S_FINISH;
                            end
                        end else begin
                            if (xfer_c && (words_seen != '1)) begin
                                words_seen <= words_seen + WORDS_W'(1);
                            end
                            if (kif.k_ap_done) begin
                                done_lat <= 1'b1;
                            end
                        end
                    end
                    S_FINISH: begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    S_ERR: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state   <= S_IDLE;
                        start_q <= 1'b0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hls_run_ctrl.sv
// Self-checking bench for hls_run_ctrl: directed scenarios plus randomized multi-run sequences.
module tb_hls_run_ctrl;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        cfg_start;
    logic [15:0] cfg_num_runs;
    logic [31:0] cfg_words_per_run;
    logic [23:0] cfg_timeout;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  err_code;
    logic [15:0] runs_done;
    logic [31:0] words_seen;

    int total = 0;
    int bad = 0;
    int hs_cnt = 0;
    int done_cnt = 0;
    int start_hi = 0;

    hls_run_ctrl_if kif ();

    hls_run_ctrl dut (
        .ap_clk            (ap_clk),
        .ap_rst            (ap_rst),
        .cfg_start         (cfg_start),
        .cfg_num_runs      (cfg_num_runs),
        .cfg_words_per_run (cfg_words_per_run),
        .cfg_timeout       (cfg_timeout),
        .kif               (kif),
        .busy              (busy),
        .done              (done),
        .error             (error),
        .err_code          (err_code),
        .runs_done         (runs_done),
        .words_seen        (words_seen)
    );

    always #5 ap_clk = ~ap_clk;

    // Event counters sampled on the active edge; inputs only change 1 time unit after it.
    always @(posedge ap_clk) begin
        if (kif.k_ap_start === 1'b1 && kif.k_ap_ready === 1'b1) hs_cnt++;
        if (done === 1'b1) done_cnt++;
        if (kif.k_ap_start === 1'b1) start_hi++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    // Pulses cfg_start, then scrambles the cfg inputs so only the sampled values matter.
    task automatic pulse_start(input int runs, input int words, input int tmo);
        tick();
        tick();
        cfg_num_runs      = 16'(runs);
        cfg_words_per_run = 32'(words);
        cfg_timeout       = 24'(tmo);
        cfg_start         = 1'b1;
        tick();
        cfg_start         = 1'b0;
        cfg_num_runs      = 16'($urandom);
        cfg_words_per_run = 32'($urandom);
        cfg_timeout       = 24'($urandom_range(1, 3));
    endtask

    // Behaves as one kernel invocation: waits for ap_start, acks, emits nw transfers, then ap_done.
    task automatic kernel_run(input int lat, input int nw, output bit ok);
        int n;
        n = 0;
        while (kif.k_ap_start !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        ok = (kif.k_ap_start === 1'b1);
        if (!ok) return;
        kif.k_ap_idle = 1'b0;
        repeat (lat) tick();
        kif.k_ap_ready = 1'b1;
        tick();
        kif.k_ap_ready = 1'b0;
        for (int i = 0; i < nw; i++) begin
            repeat ($urandom_range(0, 2)) begin
                kif.mon_vld = 1'($urandom_range(0, 1));
                kif.mon_ack = 1'b0;
                tick();
            end
            kif.mon_vld = 1'b1;
            kif.mon_ack = 1'b1;
            tick();
            kif.mon_vld = 1'b0;
            kif.mon_ack = 1'b0;
        end
        kif.k_ap_done = 1'b1;
        tick();
        kif.k_ap_done = 1'b0;
        kif.k_ap_idle = 1'b1;
    endtask

    // Complete sequence that must finish cleanly: runs handshakes, one done pulse, no error.
    task automatic do_runs(input int runs, input int words, input int tmo, input int lat);
        int hs0;
        int dn0;
        int n;
        int nw;
        bit ok;
        hs0 = hs_cnt;
        dn0 = done_cnt;
        pulse_start(runs, words, tmo);
        check("busy_on_accept", 64'(busy), 64'(1));
        for (int r = 0; r < runs; r++) begin
            nw = (words == 0) ? int'($urandom_range(0, 3)) : words;
            kernel_run(lat, nw, ok);
            check("kernel_started", 64'(ok), 64'(1));
        end
        n = 0;
        while (done !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        check("done_pulse", 64'(done), 64'(1));
        check("busy_at_done", 64'(busy), 64'(0));
        check("no_error", 64'(error), 64'(0));
        check("runs_done", 64'(runs_done), 64'(runs));
        check("words_cleared", 64'(words_seen), 64'(0));
        check("handshakes", 64'(hs_cnt - hs0), 64'(runs));
        tick();
        check("done_one_cycle", 64'(done), 64'(0));
        check("done_count", 64'(done_cnt - dn0), 64'(1));
    endtask

    initial begin
        int hs0;
        int dn0;
        int sh0;
        int waited;
        bit ok;

        ap_rst            = 1'b1;
        cfg_start         = 1'b0;
        cfg_num_runs      = '0;
        cfg_words_per_run = '0;
        cfg_timeout       = '0;
        kif.k_ap_ready    = 1'b0;
        kif.k_ap_done     = 1'b0;
        kif.k_ap_idle     = 1'b1;
        kif.mon_vld       = 1'b0;
        kif.mon_ack       = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_error", 64'(error), 64'(0));
        check("rst_err_code", 64'(err_code), 64'(0));
        check("rst_runs_done", 64'(runs_done), 64'(0));
        check("rst_words_seen", 64'(words_seen), 64'(0));
        check("rst_k_ap_start", 64'(kif.k_ap_start), 64'(0));
        ap_rst = 1'b0;
        tick();

        // Three runs of four words, ready two cycles after start
        do_runs(3, 4, 0, 2);

        // Zero runs: no kernel start, done two cycles after cfg_start
        sh0 = start_hi;
        dn0 = done_cnt;
        pulse_start(0, 4, 0);
        check("zr_busy_c1", 64'(busy), 64'(1));
        check("zr_done_c1", 64'(done), 64'(0));
        tick();
        check("zr_done_c2", 64'(done), 64'(1));
        check("zr_busy_c2", 64'(busy), 64'(0));
        tick();
        check("zr_done_c3", 64'(done), 64'(0));
        check("zr_no_start", 64'(start_hi - sh0), 64'(0));
        check("zr_done_count", 64'(done_cnt - dn0), 64'(1));

        // Overrun: five transfers against a target of four
        dn0 = done_cnt;
        pulse_start(1, 4, 0);
        kif.k_ap_ready = 1'b1;
        tick();
        kif.k_ap_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            kif.mon_vld = 1'b1;
            kif.mon_ack = 1'b1;
            tick();
            if (i == 3) begin
                check("ovr_words_4", 64'(words_seen), 64'(4));
                check("ovr_no_err_yet", 64'(error), 64'(0));
            end
        end
        kif.mon_vld = 1'b0;
        kif.mon_ack = 1'b0;
        check("ovr_error", 64'(error), 64'(1));
        check("ovr_code", 64'(err_code), 64'(2));
        check("ovr_busy", 64'(busy), 64'(0));
        check("ovr_k_start", 64'(kif.k_ap_start), 64'(0));
        repeat (3) tick();
        check("ovr_error_sticky", 64'(error), 64'(1));
        check("ovr_no_done", 64'(done_cnt - dn0), 64'(0));

        // Timeout: kernel never asserts ap_ready
        pulse_start(2, 4, 50);
        check("tmo_err_cleared", 64'(error), 64'(0));
        waited = 0;
        repeat (44) begin
            tick();
            waited++;
        end
        check("tmo_early_error", 64'(error), 64'(0));
        check("tmo_start_held", 64'(kif.k_ap_start), 64'(1));
        while (error !== 1'b1 && waited < 80) begin
            tick();
            waited++;
        end
        check("tmo_error", 64'(error), 64'(1));
        check("tmo_latency_ok", 64'((waited >= 50) && (waited <= 52)), 64'(1));
        check("tmo_code", 64'(err_code), 64'(1));
        check("tmo_k_start", 64'(kif.k_ap_start), 64'(0));
        check("tmo_busy", 64'(busy), 64'(0));

        // Underrun: ap_done after two of four words, then silence
        pulse_start(1, 4, 20);
        kernel_run(0, 2, ok);
        check("udr_started", 64'(ok), 64'(1));
        waited = 0;
        while (error !== 1'b1 && waited < 60) begin
            tick();
            waited++;
        end
        check("udr_error", 64'(error), 64'(1));
        check("udr_code", 64'(err_code), 64'(3));
        check("udr_words", 64'(words_seen), 64'(2));

        // ap_ready and ap_done in the same cycle, word check off
        hs0 = hs_cnt;
        dn0 = done_cnt;
        pulse_start(2, 0, 0);
        for (int r = 0; r < 2; r++) begin
            kif.k_ap_ready = 1'b1;
            kif.k_ap_done  = 1'b1;
            tick();
            kif.k_ap_ready = 1'b0;
            kif.k_ap_done  = 1'b0;
            check("sc_gap_low", 64'(kif.k_ap_start), 64'(0));
            check("sc_runs_pending", 64'(runs_done), 64'(r));
            tick();
            check("sc_runs_counted", 64'(runs_done), 64'(r + 1));
            check("sc_restart", 64'(kif.k_ap_start), 64'(r == 0 ? 1 : 0));
        end
        tick();
        check("sc_done", 64'(done), 64'(1));
        tick();
        check("sc_handshakes", 64'(hs_cnt - hs0), 64'(2));
        check("sc_done_count", 64'(done_cnt - dn0), 64'(1));

        // Asynchronous reset in the middle of the second run's WAIT
        pulse_start(2, 3, 0);
        kernel_run(1, 3, ok);
        check("ar_first_run", 64'(ok), 64'(1));
        kif.k_ap_ready = 1'b1;
        tick();
        kif.k_ap_ready = 1'b0;
        kif.mon_vld = 1'b1;
        kif.mon_ack = 1'b1;
        tick();
        kif.mon_vld = 1'b0;
        kif.mon_ack = 1'b0;
        check("ar_pre_runs", 64'(runs_done), 64'(1));
        check("ar_pre_words", 64'(words_seen), 64'(1));
        #2;
        ap_rst = 1'b1;
        #1;
        check("ar_k_start", 64'(kif.k_ap_start), 64'(0));
        check("ar_busy", 64'(busy), 64'(0));
        check("ar_runs", 64'(runs_done), 64'(0));
        check("ar_words", 64'(words_seen), 64'(0));
        tick();
        ap_rst = 1'b0;
        do_runs(2, 3, 0, 1);

        // Randomized complete sequences
        for (int t = 0; t < 5; t++) begin
            do_runs(int'($urandom_range(1, 4)), int'($urandom_range(0, 5)),
                    ($urandom_range(0, 1) == 1) ? 100 : 0, int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
